branch_hazard_unit: RTL and testbench



---
 rtl/pipe_pkg.sv | 18 +
 rtl/branch_hazard_unit_if.sv | 38 +++
 rtl/hazard_match.sv | 17 +
 rtl/branch_hazard_unit.sv | 68 ++++++
 tb/tb_branch_hazard_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the decode-stage branch hazard logic.
// Holds the shadow stage tag layout and its well-known constants.
package pipe_pkg;

  localparam int REG_ADDR_BITS = 5;

  typedef struct packed {
    logic                     valid;
    logic                     we;
    logic                     load;
    logic [REG_ADDR_BITS-1:0] rd;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE_TAG = '{valid: 1'b0, we: 1'b0, load: 1'b0, rd: '0};

  localparam logic [REG_ADDR_BITS-1:0] REG_ZERO = '0;

endpackage

// File: rtl/branch_hazard_unit_if.sv
// Decode-side bundle between the pipeline control and the branch hazard unit.
// The pipeline drives the s2 instruction fields; the unit returns selects and stall.
interface branch_hazard_unit_if #(
  parameter int REG_ADDR_BITS = 5,
  parameter int CNT_BITS      = 16
);

  logic                     hold;
  logic                     flush;
  logic                     id_valid;
  logic                     id_is_branch;
  logic [REG_ADDR_BITS-1:0] id_rs1;
  logic [REG_ADDR_BITS-1:0] id_rs2;
  logic [REG_ADDR_BITS-1:0] id_rd;
  logic                     id_reg_we;
  logic                     id_is_load;
  logic                     b_r1_fwd_s4;
  logic                     b_r2_fwd_s4;
  logic                     b_r1_fwd_s5;
  logic                     b_r2_fwd_s5;
  logic                     stall_s2;
  logic [CNT_BITS-1:0]      branch_stall_cnt;

  modport master (
    output hold, flush, id_valid, id_is_branch, id_rs1, id_rs2, id_rd,
           id_reg_we, id_is_load,
    input  b_r1_fwd_s4, b_r2_fwd_s4, b_r1_fwd_s5, b_r2_fwd_s5,
           stall_s2, branch_stall_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_is_branch, id_rs1, id_rs2, id_rd,
           id_reg_we, id_is_load,
    output b_r1_fwd_s4, b_r2_fwd_s4, b_r1_fwd_s5, b_r2_fwd_s5,
           stall_s2, branch_stall_cnt
  );

endinterface

// File: rtl/hazard_match.sv
// Compares one shadow stage tag against one source register address.
// Register zero is hard-wired and never counts as a producer.
module hazard_match
  import pipe_pkg::*;
(
  input  stage_tag_t               tag_i,
  input  logic [REG_ADDR_BITS-1:0] rs_i,
  output logic                     match_o
);

  // The load flag is consumed by the caller, not by the address match.
  logic unused_load;
  assign unused_load = tag_i.load;

  assign match_o = tag_i.valid & tag_i.we & (tag_i.rd == rs_i) & (rs_i != REG_ZERO);

endmodule

// File: rtl/branch_hazard_unit.sv
// Early-branch hazard/forwarding control for the decode stage.
// Shadows s3..s5 destinations and drives the branch comparator's forward selects.
module branch_hazard_unit #(
  parameter int REG_ADDR_BITS = 5,
  parameter int CNT_BITS      = 16
) (
  input  logic                 clk,
  input  logic                 rst_,
  branch_hazard_unit_if.slave  bus
);

  import pipe_pkg::*;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  stage_tag_t          s3_q, s4_q, s5_q;
  stage_tag_t          s3_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic m3_r1, m3_r2, m4_r1, m4_r2, m5_r1, m5_r2;
  logic is_br, hazard, stall;

  hazard_match u_m3_r1 (.tag_i(s3_q), .rs_i(bus.id_rs1), .match_o(m3_r1));
  hazard_match u_m3_r2 (.tag_i(s3_q), .rs_i(bus.id_rs2), .match_o(m3_r2));
  hazard_match u_m4_r1 (.tag_i(s4_q), .rs_i(bus.id_rs1), .match_o(m4_r1));
  hazard_match u_m4_r2 (.tag_i(s4_q), .rs_i(bus.id_rs2), .match_o(m4_r2));
  hazard_match u_m5_r1 (.tag_i(s5_q), .rs_i(bus.id_rs1), .match_o(m5_r1));
  hazard_match u_m5_r2 (.tag_i(s5_q), .rs_i(bus.id_rs2), .match_o(m5_r2));

  // Anything in s3 is too late to forward; a load in s4 has no data yet.
  always_comb begin
    is_br  = bus.id_valid & bus.id_is_branch;
    hazard = m3_r1 | m3_r2 | ((m4_r1 | m4_r2) & s4_q.load);
    stall  = is_br & ~bus.flush & hazard;
  end

  always_comb begin
    s3_d = BUBBLE_TAG;
    if (!(stall | bus.flush | ~bus.id_valid)) begin
      s3_d = '{valid: 1'b1, we: bus.id_reg_we, load: bus.id_is_load, rd: bus.id_rd};
    end
    cnt_d = stall ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      s3_q  <= BUBBLE_TAG;
      s4_q  <= BUBBLE_TAG;
      s5_q  <= BUBBLE_TAG;
      cnt_q <= '0;
    end else if (!bus.hold) begin
      s5_q  <= s4_q;
      s4_q  <= s3_q;
      s3_q  <= s3_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.b_r1_fwd_s4      = is_br & m4_r1 & ~s4_q.load;
  assign bus.b_r2_fwd_s4      = is_br & m4_r2 & ~s4_q.load;
  assign bus.b_r1_fwd_s5      = is_br & m5_r1;
  assign bus.b_r2_fwd_s5      = is_br & m5_r2;
  assign bus.stall_s2         = stall;
  assign bus.branch_stall_cnt = cnt_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit: ALU/load distances, r0, flush, hold and reset.
// Expected values are hand-derived from the stage timing of each sequence.
module tb_branch_hazard_unit;

  logic clk;
  logic rst_;
  int   n_cmp;
  int   n_bad;

  branch_hazard_unit_if #(.REG_ADDR_BITS(5), .CNT_BITS(16)) bus ();

  branch_hazard_unit #(.REG_ADDR_BITS(5), .CNT_BITS(16)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic br, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic ld);
    bus.id_valid     = v;
    bus.id_is_branch = br;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_reg_we    = we;
    bus.id_is_load   = ld;
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_      = 1'b0;
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    idle();
    tick();
    tick();
    rst_ = 1'b1;
  endtask

  task automatic chk_fwd(input string tag, input logic r1s4, input logic r2s4,
                         input logic r1s5, input logic r2s5);
    chk_eq({tag, ".r1s4"}, {31'd0, bus.b_r1_fwd_s4}, {31'd0, r1s4});
    chk_eq({tag, ".r2s4"}, {31'd0, bus.b_r2_fwd_s4}, {31'd0, r2s4});
    chk_eq({tag, ".r1s5"}, {31'd0, bus.b_r1_fwd_s5}, {31'd0, r1s5});
    chk_eq({tag, ".r2s5"}, {31'd0, bus.b_r2_fwd_s5}, {31'd0, r2s5});
  endtask

  task automatic chk_st(input string tag, input logic st, input int cnt);
    chk_eq({tag, ".stall"}, {31'd0, bus.stall_s2}, {31'd0, st});
    chk_eq({tag, ".cnt"}, {16'd0, bus.branch_stall_cnt}, cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Reset state
    do_reset();
    #1;
    chk_st("rst", 1'b0, 0);
    chk_fwd("rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // ALU producer at distance 1: one stall, then forward from s4
    do_reset();
    issue(1, 0, 5'd1, 5'd2, 5'd3, 1, 0);
    chk_st("alu1.add", 1'b0, 0);
    tick();
    issue(1, 1, 5'd3, 5'd4, 5'd0, 0, 0);
    chk_st("alu1.st", 1'b1, 0);
    chk_fwd("alu1.st", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_st("alu1.go", 1'b0, 1);
    chk_fwd("alu1.go", 1'b1, 1'b0, 1'b0, 1'b0);

    // Load producer at distance 1: two stalls, then forward from s5
    do_reset();
    issue(1, 0, 5'd1, 5'd0, 5'd5, 1, 1);
    tick();
    issue(1, 1, 5'd6, 5'd5, 5'd0, 0, 0);
    chk_st("ld.st1", 1'b1, 0);
    tick();
    chk_st("ld.st2", 1'b1, 1);
    chk_fwd("ld.st2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_st("ld.go", 1'b0, 2);
    chk_fwd("ld.go", 1'b0, 1'b0, 1'b0, 1'b1);

    // ALU producer at distance 2: no stall, both operands from s4
    do_reset();
    issue(1, 0, 5'd1, 5'd2, 5'd7, 1, 0);
    tick();
    idle();
    tick();
    issue(1, 1, 5'd7, 5'd7, 5'd0, 0, 0);
    chk_st("alu2", 1'b0, 0);
    chk_fwd("alu2", 1'b1, 1'b1, 1'b0, 1'b0);

    // r0 destination never matches
    do_reset();
    issue(1, 0, 5'd1, 5'd2, 5'd0, 1, 0);
    tick();
    issue(1, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    chk_st("r0.a", 1'b0, 0);
    chk_fwd("r0.a", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_st("r0.b", 1'b0, 0);
    chk_fwd("r0.b", 1'b0, 1'b0, 1'b0, 1'b0);

    // Hold during the load stall freezes stall and counter
    do_reset();
    issue(1, 0, 5'd1, 5'd0, 5'd5, 1, 1);
    tick();
    issue(1, 1, 5'd6, 5'd5, 5'd0, 0, 0);
    chk_st("hold.st1", 1'b1, 0);
    tick();
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st("hold.frz", 1'b1, 1);
    end
    bus.hold = 1'b0;
    #1;
    chk_st("hold.rel", 1'b1, 1);
    tick();
    chk_st("hold.go", 1'b0, 2);
    chk_fwd("hold.go", 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush overrides stall and inserts a bubble
    do_reset();
    issue(1, 0, 5'd1, 5'd2, 5'd3, 1, 0);
    tick();
    bus.flush = 1'b1;
    issue(1, 1, 5'd3, 5'd4, 5'd0, 0, 0);
    chk_st("flush", 1'b0, 0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk_st("flush.after", 1'b0, 0);
    chk_fwd("flush.after", 1'b1, 1'b0, 1'b0, 1'b0);

    // Non-branch consumer: no stall, no selects
    do_reset();
    issue(1, 0, 5'd1, 5'd2, 5'd3, 1, 0);
    tick();
    issue(1, 0, 5'd3, 5'd3, 5'd8, 1, 0);
    chk_st("nb.a", 1'b0, 0);
    chk_fwd("nb.a", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_fwd("nb.b", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while stalled clears shadow state and counter
    do_reset();
    issue(1, 0, 5'd1, 5'd0, 5'd5, 1, 1);
    tick();
    issue(1, 1, 5'd6, 5'd5, 5'd0, 0, 0);
    tick();
    chk_st("mrst.pre", 1'b1, 1);
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    idle();
    chk_st("mrst.post", 1'b0, 0);
    chk_fwd("mrst.post", 1'b0, 1'b0, 1'b0, 1'b0);
    issue(1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    chk_st("mrst.beq", 1'b0, 0);
    chk_fwd("mrst.beq", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
